// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the unified memory port arbiter.
//   arb_state_e  : arbiter FSM encoding (idle, fetch owns port, data owns port)
//   FETCH_FUNCT3 : access size issued for instruction fetches (word)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_e;

  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port (i_*), data port (d_*), pipeline stalls and the
//   shared memory command/response (mem_*) plus the sticky timeout flag.
//   modport slave  : the arbiter's view (serves i/d requests, drives memory)
//   modport master : the environment's view (pipeline stages and memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_funct3;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // pipeline stalls
  logic              stall_if;
  logic              stall_mem;
  // memory command / response
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              err;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_funct3, d_wdata,
    output d_ack, d_rdata,
    output stall_if, stall_mem,
    output mem_req, mem_we, mem_addr, mem_funct3, mem_wdata,
    input  mem_ack, mem_rdata,
    output err
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_funct3, d_wdata,
    input  d_ack, d_rdata,
    input  stall_if, stall_mem,
    input  mem_req, mem_we, mem_addr, mem_funct3, mem_wdata,
    output mem_ack, mem_rdata,
    input  err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Counts busy cycles that pass without a memory completion and flags the
//   cycle on which the transaction must be abandoned.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count (new grant)
//   en       : a busy cycle with no completion
//   expire   : en while the count has reached TIMEOUT-1
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and the data stage.
//   Data (older instruction) has fixed priority; a fetch in progress is never
//   preempted. Fetches killed by a taken branch complete silently, and a
//   watchdog aborts transactions that never receive mem_ack.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave carrying the i_*, d_*, stall_*,
//              mem_* and err signals
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  mem_port_arbiter_if.slave    bus
);

  arb_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              busy;
  logic              expire;
  logic              ack_event;
  logic              load_i;
  logic              load_d;
  logic              i_ack;
  logic              d_ack;
  logic [DATA_W-1:0] rdata_src;

  assign busy      = (state_q != ARB_IDLE);
  // A transaction ends either on a real completion or on a watchdog abort.
  assign ack_event = busy && (bus.mem_ack || expire);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (load_i || load_d),
    .en     (busy && !bus.mem_ack),
    .expire (expire)
  );

  // Next state and command capture. Once the owner is acked only the other
  // requester is considered, so the same requester always sees an idle cycle
  // between back-to-back grants.
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    err_d    = err_q || expire;
    load_i   = 1'b0;
    load_d   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (bus.d_req) begin
          load_d = 1'b1;
        end else if (bus.i_req) begin
          load_i = 1'b1;
        end
      end
      ARB_IBUSY: begin
        if (bus.i_flush) begin
          kill_d = 1'b1;
        end
        if (ack_event) begin
          kill_d = 1'b0;
          if (!expire && bus.d_req) begin
            load_d = 1'b1;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_DBUSY: begin
        if (ack_event) begin
          if (!expire && bus.i_req) begin
            load_i = 1'b1;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        kill_d  = 1'b0;
      end
    endcase

    we_d     = we_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    if (load_d) begin
      state_d  = ARB_DBUSY;
      we_d     = bus.d_we;
      addr_d   = bus.d_addr;
      funct3_d = bus.d_funct3;
      wdata_d  = bus.d_wdata;
    end else if (load_i) begin
      state_d  = ARB_IBUSY;
      we_d     = 1'b0;
      addr_d   = bus.i_addr;
      funct3_d = FETCH_FUNCT3;
      wdata_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
    end
  end

  // A flush coinciding with the completion kills the fetch just like an
  // earlier flush; an abort returns zero instead of whatever is on mem_rdata.
  assign i_ack     = (state_q == ARB_IBUSY) && ack_event && !kill_q && !bus.i_flush;
  assign d_ack     = (state_q == ARB_DBUSY) && ack_event;
  assign rdata_src = expire ? '0 : bus.mem_rdata;

  assign bus.i_ack      = i_ack;
  assign bus.d_ack      = d_ack;
  assign bus.i_rdata    = i_ack ? rdata_src : '0;
  assign bus.d_rdata    = d_ack ? rdata_src : '0;
  assign bus.stall_if   = bus.i_req && !i_ack;
  assign bus.stall_mem  = bus.d_req && !d_ack;
  assign bus.mem_req    = busy;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_funct3 = funct3_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios for the memory port arbiter: reset, single fetch,
//   data priority with direct hand-over, branch kill, coincident kill,
//   watchdog abort and reset during a busy transaction.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.i_flush   = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_funct3  = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", bus.mem_req); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", bus.err); end
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_funct3, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_cmd got we=%0b addr=%h f3=%0d wdata=%h want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_funct3, bus.mem_wdata);
    end
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.stall_if, bus.stall_mem} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_acks got i_ack=%0b d_ack=%0b stall_if=%0b stall_mem=%0b want 0",
               bus.i_ack, bus.d_ack, bus.stall_if, bus.stall_mem);
    end
  endtask

  task automatic test_fetch();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h40;
    #1;
    checks++;
    if (bus.stall_if !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_request_cycle got stall_if=%0b mem_req=%0b want 1 0", bus.stall_if, bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_funct3 !== 3'b010 ||
        bus.mem_we !== 1'b0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL fetch_cmd got req=%0b addr=%h f3=%0d we=%0b wdata=%h want 1 40 2 0 0",
               bus.mem_req, bus.mem_addr, bus.mem_funct3, bus.mem_we, bus.mem_wdata);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.i_ack !== 1'b0 || bus.stall_if !== 1'b1) begin
        errors++;
        $display("FAIL fetch_wait%0d got i_ack=%0b stall_if=%0b want 0 1", c, bus.i_ack, bus.stall_if);
      end
      tick();
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    #1;
    checks++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h00500093 || bus.stall_if !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack got i_ack=%0b i_rdata=%h stall_if=%0b want 1 00500093 0",
               bus.i_ack, bus.i_rdata, bus.stall_if);
    end
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.i_req     = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0 || bus.i_rdata !== '0) begin
      errors++;
      $display("FAIL fetch_done got mem_req=%0b i_ack=%0b i_rdata=%h want 0 0 0",
               bus.mem_req, bus.i_ack, bus.i_rdata);
    end
  endtask

  task automatic test_priority();
    bus.i_req    = 1'b1;
    bus.i_addr   = 32'h44;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h80;
    bus.d_wdata  = 32'hDEADBEEF;
    bus.d_funct3 = 3'b010;
    tick();
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h80 || bus.mem_wdata !== 32'hDEADBEEF ||
        bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL prio_data_first got we=%0b addr=%h wdata=%h stall_if=%0b stall_mem=%0b want 1 80 deadbeef 1 1",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stall_if, bus.stall_mem);
    end
    tick();
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL prio_d_ack got d_ack=%0b i_ack=%0b stall_mem=%0b want 1 0 0", bus.d_ack, bus.i_ack, bus.stall_mem);
    end
    tick();
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44 || bus.mem_we !== 1'b0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL prio_handover got req=%0b addr=%h we=%0b wdata=%h want 1 44 0 0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
    end
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11;
    #1;
    checks++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h11 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL prio_i_ack got i_ack=%0b i_rdata=%h d_rdata=%h want 1 11 0", bus.i_ack, bus.i_rdata, bus.d_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h48;
    tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h22;
    #1;
    checks++;
    if (bus.i_ack !== 1'b0 || bus.i_rdata !== '0 || bus.stall_if !== 1'b1) begin
      errors++;
      $display("FAIL flush_killed got i_ack=%0b i_rdata=%h stall_if=%0b want 0 0 1", bus.i_ack, bus.i_rdata, bus.stall_if);
    end
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.i_addr    = 32'h100;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_idle got mem_req=%0b want 0", bus.mem_req); end
    tick();
    checks++;
    if (bus.mem_addr !== 32'h100 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_refetch_cmd got addr=%h req=%0b want 100 1", bus.mem_addr, bus.mem_req);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h33;
    #1;
    checks++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h33) begin
      errors++;
      $display("FAIL flush_refetch_ack got i_ack=%0b i_rdata=%h want 1 33", bus.i_ack, bus.i_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_same_cycle();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h50;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    bus.i_flush   = 1'b1;
    #1;
    checks++;
    if (bus.i_ack !== 1'b0 || bus.i_rdata !== '0) begin
      errors++;
      $display("FAIL flush_coincident got i_ack=%0b i_rdata=%h want 0 0", bus.i_ack, bus.i_rdata);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_coincident_idle got mem_req=%0b want 0", bus.mem_req); end
  endtask

  task automatic test_timeout();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h90;
    bus.d_funct3  = 3'b010;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    for (int c = 1; c < TIMEOUT; c++) begin
      checks++;
      if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait%0d got d_ack=%0b mem_req=%0b want 0 1", c, bus.d_ack, bus.mem_req);
      end
      tick();
    end
    checks++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== '0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort got d_ack=%0b d_rdata=%h err=%0b want 1 0 0", bus.d_ack, bus.d_rdata, bus.err);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.err !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err got err=%0b mem_req=%0b want 1 0", bus.err, bus.mem_req);
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h60;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h44;
    #1;
    checks++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h44 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next got i_ack=%0b i_rdata=%h err=%0b want 1 44 1", bus.i_ack, bus.i_rdata, bus.err);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'hA0;
    bus.d_funct3 = 3'b100;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hA0) begin
      errors++;
      $display("FAIL rstbusy_grant got mem_req=%0b addr=%h want 1 a0", bus.mem_req, bus.mem_addr);
    end
    rst       = 1'b1;
    bus.d_req = 1'b0;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55;
    #1;
    checks++;
    if (bus.d_ack !== 1'b0 || bus.d_rdata !== '0 || bus.mem_req !== 1'b0 || bus.err !== 1'b0 ||
        bus.mem_addr !== '0 || bus.mem_funct3 !== '0) begin
      errors++;
      $display("FAIL rstbusy_outputs got d_ack=%0b d_rdata=%h mem_req=%0b err=%0b addr=%h f3=%0d want all 0",
               bus.d_ack, bus.d_rdata, bus.mem_req, bus.err, bus.mem_addr, bus.mem_funct3);
    end
    rst = 1'b0;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_idle got mem_req=%0b d_ack=%0b want 0 0", bus.mem_req, bus.d_ack);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_flush_same_cycle();
    test_timeout();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
